instr_fetch_issue: RTL and testbench
====================================

INSTR_FETCH_ISSUE -- requirements
Module: instr_fetch_issue

Interface
REQ-001 The block SHALL use a single clock and a synchronous active-high reset: clk1 input 1, the only clock, rising-edge; rst input 1, synchronous active-high reset.
REQ-002 Ports SHALL be as follows:
- start, input, 1: one-cycle pulse that begins fetching at start_pc.
- start_pc, input, 8: initial program counter.
- imem_we, input, 1: instruction memory write enable.
- imem_waddr, input, 8: instruction memory write address.
- imem_wdata, input, 24: instruction word {rd[23:20], rs1[19:16], rs2[15:12], func[11:8], addr[7:0]}.
- out_valid, output, 1: issue slot holds a valid instruction.
- out_ready, input, 1: downstream stage accepts the issue slot.
- rd, rs1, rs2, output, 4 each: decoded register fields.
- func, output, 4: decoded ALU function.
- addr, output, 8: decoded memory address.
- pc_out, output, 8: address the issued instruction was fetched from.
- busy, output, 1: the FSM is in RUN or DRAIN.
- halted, output, 1: the FSM is in HALT.
- stall_cnt, output, 16: present only with FETCH_PERF_EN.

Function
REQ-003 The block SHALL contain a 256x24 instruction memory:
- Write is synchronous on imem_we.
- Read is synchronous with 1-cycle latency.
- A same-address read and write in the same cycle returns the old data.
REQ-004 FSM states SHALL be IDLE, RUN, DRAIN and HALT. Transitions:
- IDLE->RUN on start.
- RUN->DRAIN when a returned word has func==4'hF.
- DRAIN->HALT when the FIFO is empty.
- HALT->RUN on start.
REQ-005 start SHALL be ignored in RUN and DRAIN. On an accepted start, pc loads start_pc.
REQ-006 An output FIFO SHALL be 2 entries deep. Its head drives out_valid, rd, rs1, rs2, func, addr and pc_out. A pop occurs when out_valid && out_ready.
REQ-007 In RUN, the block SHALL issue a read of pc and increment pc only when (fifo_count + inflight − pop) < 2.
REQ-008 pc SHALL wrap from 8'hFF to 8'h00.
REQ-009 A returned non-halt word SHALL be pushed into the FIFO on the following edge.
REQ-010 The halt word SHALL NOT be pushed. Any word returning after it SHALL be discarded.
REQ-011 Latency: with start sampled on edge E0, the read of start_pc SHALL issue on E1 and out_valid SHALL be 1 after E2.
REQ-012 Throughput SHALL be 1 instruction per cycle while out_ready is held at 1.
REQ-013 Outputs SHALL hold stable while out_valid && !out_ready. No instruction may be lost or duplicated under any out_ready pattern.
REQ-014 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-015 While the FIFO is empty, out_valid SHALL be 0 and the field outputs SHALL hold their last value.
REQ-016 busy SHALL be 1 in RUN and DRAIN. halted SHALL be 1 in HALT.

Reset
REQ-017 When rst is sampled high, the block SHALL apply the following on that edge regardless of state:
- state=IDLE.
- pc=0, fifo_count=0, inflight=0.
- out_valid=0, busy=0, halted=0.
- rd=rs1=rs2=func=0, addr=0, pc_out=0.
- stall_cnt=0.
REQ-018 Reset SHALL NOT clear the instruction memory contents.
REQ-019 rst SHALL take priority over start and imem_we in the same cycle; imem_we is ignored while rst=1.
REQ-020 After rst deasserts mid-run, out_valid SHALL remain 0 until a new start.

Configuration
REQ-021 With FETCH_PERF_EN defined, stall_cnt SHALL increment by 1 every cycle out_valid && !out_ready, and SHALL saturate at 16'hFFFF.
REQ-022 With FETCH_PERF_EN undefined, the stall_cnt port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 Load mem[125]=24'hA3_50_7D and mem[126]=24'h000F00; pulse start with start_pc=125, out_ready=1. Required: out_valid=1 exactly 2 cycles after start, with rd=A, rs1=3, rs2=5, func=0, addr=125, pc_out=125. Then DRAIN, then halted=1; no second instruction is issued.
REQ-024 Load mem[0..9] with non-halt words and mem[10] with a halt word; toggle out_ready 1,0,0,1,... Required: pc_out sequence 0..9 in order with no gaps or repeats, and outputs stable while stalled.
REQ-025 Load mem[254], mem[255] and mem[0] with non-halt words and mem[1] with a halt word; start at 254. Required: pc_out sequence 254, 255, 0, then halt.
REQ-026 Assert rst for 1 cycle after 3 instructions have issued. Required: out_valid=0, busy=0 and fields=0 on the next cycle, and memory contents intact on re-start.
REQ-027 With FETCH_PERF_EN defined, hold out_ready=0 for 7 cycles after out_valid rises. Required: stall_cnt=7.
REQ-028 Pulse start during RUN with a different start_pc. Required: the start is ignored and the pc_out sequence continues unchanged.

Source files
------------

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue stage: 256x24 instruction memory, fetch FSM and a
// 2-entry output FIFO whose head is the issue slot.
// Optional build macro FETCH_PERF_EN adds the stall_cnt port and its
// saturating counter of cycles where the issue slot is valid but not taken.
module instr_fetch_issue (
   input  logic        clk1,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  start_pc,
   input  logic        imem_we,
   input  logic [7:0]  imem_waddr,
   input  logic [23:0] imem_wdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  rd,
   output logic [3:0]  rs1,
   output logic [3:0]  rs2,
   output logic [3:0]  func,
   output logic [7:0]  addr,
   output logic [7:0]  pc_out,
   output logic        busy,
   output logic        halted
`ifdef FETCH_PERF_EN
   ,output logic [15:0] stall_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

   // One FIFO slot: the raw instruction word plus the address it came from.
   typedef struct packed {
      logic [23:0] word;
      logic [7:0]  pc;
   } entry_t;

   logic [23:0] mem [256];
   state_t      state, state_nxt;
   logic [7:0]  pc;
   logic [7:0]  rd_pc;
   logic [23:0] rd_word;
   logic        inflight;
   logic [1:0]  fifo_count;
   entry_t      head, tail, new_entry;
   logic        issue, push, pop, ret_halt, start_ok;

   // Handshake and fetch-credit decode for the current cycle.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      pop       = 1'b0;
      ret_halt  = 1'b0;
      push      = 1'b0;
      issue     = 1'b0;
      start_ok  = 1'b0;
      new_entry = '{word: rd_word, pc: rd_pc};
      pop       = (fifo_count != 2'd0) && out_ready;
      ret_halt  = inflight && (rd_word[11:8] == 4'hF);
      // Words returning outside RUN (after the halt word) are dropped.
      push      = inflight && (state == S_RUN) && !ret_halt;
      // Occupied slots plus the word in flight, minus this cycle's pop,
      // must leave room for one more fetch.
      issue     = (state == S_RUN) &&
                  (({1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop}) < 3'd2);
      start_ok  = start && ((state == S_IDLE) || (state == S_HALT));
   end

   // Next-state logic for the fetch FSM.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start)               state_nxt = S_RUN;
         S_RUN:   if (ret_halt)            state_nxt = S_DRAIN;
         S_DRAIN: if (fifo_count == 2'd0)  state_nxt = S_HALT;
         S_HALT:  if (start)               state_nxt = S_RUN;
         default:                          state_nxt = S_IDLE;
      endcase
   end

   // Instruction memory: synchronous write, registered read (old data on collision).
   always_ff @(posedge clk1) begin
      // NOTE: the memory array and read register are deliberately not reset;
      // program contents must survive rst, and a reset port would prevent
      // mapping the array onto RAM.
      if (imem_we && !rst) mem[imem_waddr] <= imem_wdata;
      if (issue) begin
         rd_word <= mem[pc];
         rd_pc   <= pc;
      end
   end

   // FSM state, program counter and in-flight read flag.
   always_ff @(posedge clk1) begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state    <= S_IDLE;
         pc       <= 8'h00;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (start_ok)   pc <= start_pc;
         else if (issue) pc <= pc + 8'd1;   // wraps FF -> 00
      end
   end

   // Two-slot FIFO as head/tail registers; the head keeps its last value when emptied.
   always_ff @(posedge clk1) begin
      if (rst) begin
         fifo_count <= 2'd0;
         head       <= '0;
         tail       <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (fifo_count == 2'd0) head <= new_entry;
               else                    tail <= new_entry;
               fifo_count <= fifo_count + 2'd1;
            end
            2'b01: begin
               if (fifo_count == 2'd2) head <= tail;
               fifo_count <= fifo_count - 2'd1;
            end
            2'b11: begin
               if (fifo_count == 2'd2) begin
                  head <= tail;
                  tail <= new_entry;
               end else begin
                  head <= new_entry;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (fifo_count != 2'd0);
   assign rd        = head.word[23:20];
   assign rs1       = head.word[19:16];
   assign rs2       = head.word[15:12];
   assign func      = head.word[11:8];
   assign addr      = head.word[7:0];
   assign pc_out    = head.pc;
   assign busy      = (state == S_RUN) || (state == S_DRAIN);
   assign halted    = (state == S_HALT);

`ifdef FETCH_PERF_EN
   // Saturating count of cycles the issue slot is valid but not accepted.
   always_ff @(posedge clk1) begin
      if (rst)                                               stall_cnt <= 16'h0000;
      else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue. Expected issue order is derived
// from a bench-side copy of the instruction memory when start is driven and
// compared as the DUT hands instructions downstream.
module tb_instr_fetch_issue;

   typedef struct packed {
      logic [7:0]  pc;
      logic [23:0] word;
   } exp_t;

   logic        clk1 = 1'b0;
   logic        rst, start, imem_we, out_ready;
   logic [7:0]  start_pc, imem_waddr;
   logic [23:0] imem_wdata;
   logic        out_valid, busy, halted;
   logic [3:0]  rd, rs1, rs2, func;
   logic [7:0]  addr, pc_out;
`ifdef FETCH_PERF_EN
   logic [15:0] stall_cnt;
`endif

   logic [23:0] cur_word;
   assign cur_word = {rd, rs1, rs2, func, addr};

   logic [23:0] model_mem [256];
   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_pops   = 0;

   instr_fetch_issue dut (
      .clk1(clk1), .rst(rst), .start(start), .start_pc(start_pc),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .rd(rd), .rs1(rs1), .rs2(rs2), .func(func), .addr(addr),
      .pc_out(pc_out), .busy(busy), .halted(halted)
`ifdef FETCH_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk1 = ~clk1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Downstream monitor: scoreboard compare on every accepted issue, and
   // stability check on the cycle following a stall.
   logic        mon_stalled = 1'b0;
   logic [7:0]  held_pc;
   logic [23:0] held_word;
   always @(negedge clk1) begin : monitor
      exp_t e;
      if (mon_stalled && !rst) begin
         check("hold_valid", {31'd0, out_valid}, 32'd1);
         check("hold_pc", {24'd0, pc_out}, {24'd0, held_pc});
         check("hold_word", {8'd0, cur_word}, {8'd0, held_word});
      end
      mon_stalled = out_valid && !out_ready && !rst;
      held_pc     = pc_out;
      held_word   = cur_word;
      if (out_valid && out_ready && !rst) begin
         n_pops++;
         if (sb.size() == 0) begin
            check("unexpected_issue", {24'd0, pc_out}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("issue_pc", {24'd0, pc_out}, {24'd0, e.pc});
            check("issue_word", {8'd0, cur_word}, {8'd0, e.word});
         end
      end
   end

   task automatic write_mem(input logic [7:0] a, input logic [23:0] d);
      imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
      @(posedge clk1); #1;
      imem_we = 1'b0;
      model_mem[a] = d;
   endtask

   // Pulse start and queue the instructions the bench model expects to issue.
   task automatic start_at(input logic [7:0] a0);
      logic [7:0]  a;
      logic [23:0] w;
      a = a0;
      for (int k = 0; k < 256; k++) begin
         w = model_mem[a];
         if (w[11:8] == 4'hF) break;
         sb.push_back('{pc: a, word: w});
         a = a + 8'd1;
      end
      start = 1'b1; start_pc = a0;
      @(posedge clk1); #1;
      start = 1'b0;
   endtask

   // mode 0: ready held high, 1: pattern 1,0,0 repeating, 2: random.
   task automatic run_until_halt(input int mode, input int budget);
      for (int i = 0; i < budget && !halted; i++) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (i % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         @(posedge clk1); #1;
      end
      check("halt_reached", {31'd0, halted}, 32'd1);
      check("halt_not_busy", {31'd0, busy}, 32'd0);
      check("sb_drained", sb.size(), 32'd0);
      out_ready = 1'b1;
   endtask

   function automatic logic [23:0] plain_word(input int i);
      plain_word = {4'(i), 4'(i + 1), 4'(i + 5), 4'(i % 15), 8'(i * 7 + 1)};
   endfunction

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      for (int i = 0; i < 256; i++) model_mem[i] = 24'h0;
      rst = 1'b1; start = 1'b0; start_pc = 8'h00; imem_we = 1'b0;
      imem_waddr = 8'h00; imem_wdata = 24'h0; out_ready = 1'b0;
      repeat (3) @(posedge clk1);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_fields", {8'd0, cur_word}, 32'd0);
      check("rst_pc_out", {24'd0, pc_out}, 32'd0);
      rst = 1'b0;

      // Single instruction then halt; latency of two edges after start.
      write_mem(8'd125, 24'hA3507D);
      write_mem(8'd126, 24'h000F00);
      write_mem(8'd127, 24'h123456);
      out_ready = 1'b1;
      base = n_pops;
      start_at(8'd125);
      check("lat_e0_valid", {31'd0, out_valid}, 32'd0);
      check("lat_e0_busy", {31'd0, busy}, 32'd1);
      @(posedge clk1); #1;
      check("lat_e1_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk1); #1;
      check("lat_e2_valid", {31'd0, out_valid}, 32'd1);
      check("lat_e2_rd", {28'd0, rd}, 32'hA);
      check("lat_e2_rs1", {28'd0, rs1}, 32'h3);
      check("lat_e2_rs2", {28'd0, rs2}, 32'h5);
      check("lat_e2_func", {28'd0, func}, 32'h0);
      check("lat_e2_addr", {24'd0, addr}, 32'd125);
      check("lat_e2_pc_out", {24'd0, pc_out}, 32'd125);
      run_until_halt(0, 50);
      check("single_issue_count", n_pops - base, 32'd1);

      // Ten instructions under a 1,0,0 ready pattern.
      for (int i = 0; i < 10; i++) write_mem(8'(i), plain_word(i));
      write_mem(8'd10, 24'h987F42);
      base = n_pops;
      start_at(8'd0);
      run_until_halt(1, 200);
      check("stall_issue_count", n_pops - base, 32'd10);

      // Reset after three issues; a write during reset must be ignored.
      out_ready = 1'b1;
      base = n_pops;
      start_at(8'd0);
      for (int i = 0; i < 50 && (n_pops - base) < 3; i++) begin
         @(posedge clk1); #1;
      end
      check("three_issued", {31'd0, 1'((n_pops - base) >= 3)}, 32'd1);
      rst = 1'b1; out_ready = 1'b0;
      imem_we = 1'b1; imem_waddr = 8'd0; imem_wdata = 24'hFFFFFF;
      @(posedge clk1); #1;
      rst = 1'b0; imem_we = 1'b0;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_fields", {8'd0, cur_word}, 32'd0);
      check("mid_rst_pc_out", {24'd0, pc_out}, 32'd0);
      sb.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk1); #1;
         check("post_rst_idle_valid", {31'd0, out_valid}, 32'd0);
      end
      base = n_pops;
      start_at(8'd0);
      run_until_halt(0, 100);
      check("restart_issue_count", n_pops - base, 32'd10);

      // Start pulsed during RUN with another start_pc must be ignored.
      for (int i = 40; i < 50; i++) write_mem(8'(i), plain_word(i));
      write_mem(8'd50, 24'h111F11);
      write_mem(8'd200, 24'hCCC3CC);
      base = n_pops;
      start_at(8'd40);
      for (int i = 0; i < 200 && !halted; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (i == 3) begin start = 1'b1; start_pc = 8'd200; end
         else        start = 1'b0;
         @(posedge clk1); #1;
      end
      start = 1'b0;
      run_until_halt(0, 50);
      check("ignore_start_count", n_pops - base, 32'd10);

      // PC wrap from FF to 00.
      write_mem(8'd254, plain_word(11));
      write_mem(8'd255, plain_word(12));
      write_mem(8'd0, plain_word(13));
      write_mem(8'd1, 24'h222F22);
      base = n_pops;
      start_at(8'd254);
      run_until_halt(1, 100);
      check("wrap_issue_count", n_pops - base, 32'd3);

`ifdef FETCH_PERF_EN
      // Seven stalled cycles after the first instruction appears.
      rst = 1'b1;
      @(posedge clk1); #1;
      rst = 1'b0;
      check("perf_rst", {16'd0, stall_cnt}, 32'd0);
      out_ready = 1'b0;
      start_at(8'd254);
      for (int i = 0; i < 10 && !out_valid; i++) begin
         @(posedge clk1); #1;
      end
      check("perf_valid_rose", {31'd0, out_valid}, 32'd1);
      repeat (7) @(posedge clk1);
      #1;
      check("perf_stall_cnt", {16'd0, stall_cnt}, 32'd7);
      run_until_halt(0, 100);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
